// File: rtl/triangle_assembler_if.sv
// Vertex-in / triangle-out handshake bundle for triangle_assembler.
// The slave modport is the assembler's view; the master modport drives it.
interface triangle_assembler_if #(
    parameter int unsigned COUNT_WIDTH = 16
);
    logic                   valid_in;
    logic                   ready_out;
    logic [3:0][31:0]       vertex_in;
    logic [11:0]            material_in;
    logic                   flush_in;
    logic                   valid_out;
    logic                   ready_in;
    logic [2:0][3:0][31:0]  triangle_out;
    logic [11:0]            material_out;
    logic                   mismatch_out;
    logic [COUNT_WIDTH-1:0] triangle_count_out;

    modport master (
        output valid_in, vertex_in, material_in, flush_in, ready_in,
        input  ready_out, valid_out, triangle_out, material_out, mismatch_out,
               triangle_count_out
    );

    modport slave (
        input  valid_in, vertex_in, material_in, flush_in, ready_in,
        output ready_out, valid_out, triangle_out, material_out, mismatch_out,
               triangle_count_out
    );
endinterface

// File: rtl/triangle_assembler.sv
// Groups every three accepted vertices into a triangle, flags mixed materials,
// and counts triangles handed to the rasterizer setup stage.
module triangle_assembler #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    triangle_assembler_if.slave  bus
);
    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [1:0]             r_slot;
    logic [1:0][3:0][31:0]  r_stage;
    logic [11:0]            r_stage_mat;
    logic                   r_stage_mis;

    logic [2:0][3:0][31:0]  r_tri;
    logic [11:0]            r_mat;
    logic                   r_mis;
    logic [COUNT_WIDTH-1:0] r_count;

    logic                   w_ready;
    logic                   w_valid;
    logic                   w_handoff;
    logic                   w_accept;
    logic [1:0]             w_slot;
    logic                   w_complete;
    logic                   w_mat_diff;

    // Flush acts before the accept, so a vertex arriving with it lands in slot 0.
    assign w_handoff  = w_valid && bus.ready_in;
    assign w_accept   = bus.valid_in && w_ready;
    assign w_slot     = bus.flush_in ? 2'd0 : r_slot;
    assign w_complete = w_accept && (w_slot == 2'd2);
    assign w_mat_diff = (bus.material_in != r_stage_mat);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: begin
                if (w_complete) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (w_complete) begin
                    w_state_nxt = FULL;
                end else if (w_handoff) begin
                    w_state_nxt = COLLECT;
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        w_valid = (r_state == FULL);
        w_ready = (r_state == COLLECT) || (w_valid && bus.ready_in);
    end

    // Slots 0/1 live in staging so the presented triangle never changes before handoff.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_slot      <= '0;
            r_stage     <= '0;
            r_stage_mat <= '0;
            r_stage_mis <= 1'b0;
            r_tri       <= '0;
            r_mat       <= '0;
            r_mis       <= 1'b0;
            r_count     <= '0;
        end else begin
            if (bus.flush_in) begin
                r_slot      <= '0;
                r_stage_mis <= 1'b0;
            end
            if (w_accept) begin
                if (w_complete) begin
                    r_tri  <= {bus.vertex_in, r_stage[1], r_stage[0]};
                    r_mat  <= r_stage_mat;
                    r_mis  <= r_stage_mis | w_mat_diff;
                    r_slot <= '0;
                end else begin
                    r_stage[w_slot[0]] <= bus.vertex_in;
                    r_slot             <= w_slot + 2'd1;
                    if (w_slot == 2'd0) begin
                        r_stage_mat <= bus.material_in;
                        r_stage_mis <= 1'b0;
                    end else begin
                        r_stage_mis <= r_stage_mis | w_mat_diff;
                    end
                end
            end
            if (w_handoff) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign bus.ready_out          = w_ready;
    assign bus.valid_out          = w_valid;
    assign bus.triangle_out       = r_tri;
    assign bus.material_out       = r_mat;
    assign bus.mismatch_out       = r_mis;
    assign bus.triangle_count_out = r_count;

endmodule

// File: tb/tb_triangle_assembler.sv
// Directed bench for triangle_assembler with a 2-bit triangle counter so that
// counter wrap is reachable in a short run.
module tb_triangle_assembler;
    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    triangle_assembler_if #(.COUNT_WIDTH(2)) bus ();

    triangle_assembler #(.COUNT_WIDTH(2)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [127:0] vtx(input logic [31:0] x);
        return {x + 32'd300, x + 32'd200, x + 32'd100, x};
    endfunction

    function automatic logic [383:0] mk_tri(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        return {vtx(c), vtx(b), vtx(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] x, input logic [11:0] m);
        bus.valid_in    = v;
        bus.vertex_in   = vtx(x);
        bus.material_in = m;
    endtask

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        rst_n        = 1'b0;
        bus.flush_in = 1'b0;
        bus.ready_in = 1'b0;
        put(1'b0, 32'd0, 12'h000);
        tick();
        tick();
        chk("rst_valid", bus.valid_out, 1'b0);
        chk("rst_mis", bus.mismatch_out, 1'b0);
        chk("rst_count", bus.triangle_count_out, 2'd0);
        chk("rst_tri", bus.triangle_out, 384'd0);
        chk("rst_mat", bus.material_out, 12'h000);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", bus.ready_out, 1'b1);

        // Basic triangle, one-cycle latency, handoff bumps the count.
        bus.ready_in = 1'b1;
        put(1'b1, 32'd1, 12'h005); tick();
        put(1'b1, 32'd2, 12'h005); tick();
        put(1'b1, 32'd3, 12'h005); tick();
        put(1'b0, 32'd0, 12'h000);
        chk("t1_valid", bus.valid_out, 1'b1);
        chk("t1_tri", bus.triangle_out, mk_tri(32'd1, 32'd2, 32'd3));
        chk("t1_mat", bus.material_out, 12'h005);
        chk("t1_mis", bus.mismatch_out, 1'b0);
        chk("t1_count0", bus.triangle_count_out, 2'd0);
        tick();
        chk("t1_count1", bus.triangle_count_out, 2'd1);
        chk("t1_valid_drop", bus.valid_out, 1'b0);

        // Nine-vertex stream without bubbles.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            put(1'b1, 32'(16 + i), 12'h0aa);
            #1;
            chk("stream_ready", bus.ready_out, 1'b1);
            tick();
            if (i % 3 == 2) begin
                chk("stream_valid", bus.valid_out, 1'b1);
                chk("stream_tri", bus.triangle_out,
                    mk_tri(32'(16 + i - 2), 32'(16 + i - 1), 32'(16 + i)));
            end
        end
        put(1'b0, 32'd0, 12'h000);
        tick();
        chk("stream_count", bus.triangle_count_out, 2'd3);
        chk("stream_valid_end", bus.valid_out, 1'b0);

        // Backpressure: held triangle stays put, waiting vertex enters on handoff.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        bus.ready_in = 1'b0;
        put(1'b1, 32'h21, 12'h007); tick();
        put(1'b1, 32'h22, 12'h007); tick();
        put(1'b1, 32'h23, 12'h007); tick();
        put(1'b1, 32'h24, 12'h007);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("bp_ready", bus.ready_out, 1'b0);
            chk("bp_tri", bus.triangle_out, mk_tri(32'h21, 32'h22, 32'h23));
            chk("bp_valid", bus.valid_out, 1'b1);
            tick();
        end
        bus.ready_in = 1'b1;
        #1;
        chk("bp_ready_handoff", bus.ready_out, 1'b1);
        tick();
        chk("bp_count", bus.triangle_count_out, 2'd1);
        chk("bp_valid_drop", bus.valid_out, 1'b0);
        put(1'b1, 32'h25, 12'h007); tick();
        put(1'b1, 32'h26, 12'h007); tick();
        put(1'b0, 32'd0, 12'h000);
        chk("bp_next_valid", bus.valid_out, 1'b1);
        chk("bp_next_tri", bus.triangle_out, mk_tri(32'h24, 32'h25, 32'h26));
        tick();
        chk("bp_count2", bus.triangle_count_out, 2'd2);

        // Material mismatch, uniform follow-up, and sticky slot-1 mismatch.
        bus.ready_in = 1'b0;
        put(1'b1, 32'h31, 12'h001); tick();
        put(1'b1, 32'h32, 12'h001); tick();
        put(1'b1, 32'h33, 12'h002); tick();
        chk("mm_valid", bus.valid_out, 1'b1);
        chk("mm_mis", bus.mismatch_out, 1'b1);
        chk("mm_mat", bus.material_out, 12'h001);
        put(1'b1, 32'h34, 12'h003);
        bus.ready_in = 1'b1;
        tick();
        bus.ready_in = 1'b0;
        put(1'b1, 32'h35, 12'h003); tick();
        put(1'b1, 32'h36, 12'h003); tick();
        put(1'b0, 32'd0, 12'h000);
        chk("mm_uni_mis", bus.mismatch_out, 1'b0);
        chk("mm_uni_mat", bus.material_out, 12'h003);
        chk("mm_uni_tri", bus.triangle_out, mk_tri(32'h34, 32'h35, 32'h36));
        chk("mm_count3", bus.triangle_count_out, 2'd3);
        put(1'b1, 32'h37, 12'h004);
        bus.ready_in = 1'b1;
        tick();
        bus.ready_in = 1'b0;
        put(1'b1, 32'h38, 12'h009); tick();
        put(1'b1, 32'h39, 12'h004); tick();
        put(1'b0, 32'd0, 12'h000);
        chk("mm_sticky_mis", bus.mismatch_out, 1'b1);
        chk("mm_sticky_mat", bus.material_out, 12'h004);
        chk("mm_count_wrap", bus.triangle_count_out, 2'd0);
        bus.ready_in = 1'b1;
        tick();
        chk("mm_count1", bus.triangle_count_out, 2'd1);
        bus.ready_in = 1'b0;

        // Flush: idle flush, then flush coinciding with a new slot-0 vertex.
        put(1'b1, 32'h41, 12'h001); tick();
        put(1'b1, 32'h42, 12'h002); tick();
        put(1'b0, 32'd0, 12'h000);
        bus.flush_in = 1'b1; tick(); bus.flush_in = 1'b0;
        put(1'b1, 32'h43, 12'h009); tick();
        put(1'b1, 32'h44, 12'h006);
        bus.flush_in = 1'b1;
        #1;
        chk("fl_ready", bus.ready_out, 1'b1);
        tick();
        bus.flush_in = 1'b0;
        put(1'b1, 32'h45, 12'h006); tick();
        put(1'b1, 32'h46, 12'h006); tick();
        put(1'b0, 32'd0, 12'h000);
        chk("fl_valid", bus.valid_out, 1'b1);
        chk("fl_tri", bus.triangle_out, mk_tri(32'h44, 32'h45, 32'h46));
        chk("fl_mis", bus.mismatch_out, 1'b0);
        chk("fl_mat", bus.material_out, 12'h006);
        bus.flush_in = 1'b1; tick(); bus.flush_in = 1'b0;
        chk("fl_full_valid", bus.valid_out, 1'b1);
        chk("fl_full_tri", bus.triangle_out, mk_tri(32'h44, 32'h45, 32'h46));
        bus.ready_in = 1'b1;
        tick();
        chk("fl_count", bus.triangle_count_out, 2'd2);
        chk("fl_valid_drop", bus.valid_out, 1'b0);

        // Counter wrap over five triangles, then reset mid-triangle.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            put(i < 15, 32'(80 + i), 12'h00c);
            tick();
            if (i > 0 && i % 3 == 0) begin
                chk("wrap_count", bus.triangle_count_out, wrap_exp[i / 3 - 1]);
            end
        end
        put(1'b1, 32'h70, 12'h003); tick();
        put(1'b0, 32'd0, 12'h000);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mr_valid", bus.valid_out, 1'b0);
        chk("mr_count", bus.triangle_count_out, 2'd0);
        chk("mr_tri", bus.triangle_out, 384'd0);
        bus.ready_in = 1'b0;
        put(1'b1, 32'h71, 12'h00e); tick();
        put(1'b1, 32'h72, 12'h00e); tick();
        put(1'b1, 32'h73, 12'h00e); tick();
        put(1'b0, 32'd0, 12'h000);
        chk("mr_clean_valid", bus.valid_out, 1'b1);
        chk("mr_clean_tri", bus.triangle_out, mk_tri(32'h71, 32'h72, 32'h73));
        chk("mr_clean_mis", bus.mismatch_out, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/triangle_assembler.md
Name: triangle_assembler

Overview:
- Sits directly downstream of the triangle FIFO; consumes its per-vertex valid/ready stream (one 4x32-bit vertex plus a 12-bit material per beat).
- Groups every three consecutive accepted vertices into one triangle and presents it with its material to the rasterizer setup stage over a valid/ready interface.
- Flags triangles whose three vertex materials disagree, and keeps a running count of emitted triangles.

Parameters:
- COUNT_WIDTH, 16, width of the emitted-triangle counter; wraps modulo 2^COUNT_WIDTH.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  synchronous reset, active low
- valid_in  input  1  upstream vertex valid
- ready_out  output  1  block can accept a vertex this cycle
- vertex_in  input  128  vertex, packed [3:0][31:0], lane0=x, lane1=y, lane2=z, lane3=w; opaque to this block
- material_in  input  12  material ID tagged on this vertex
- flush_in  input  1  discard any partially collected triangle
- valid_out  output  1  assembled triangle available
- ready_in  input  1  downstream accepts triangle
- triangle_out  output  384  packed [2:0][3:0][31:0]; index 0 = first vertex accepted
- material_out  output  12  material of vertex 0
- mismatch_out  output  1  with valid_out: vertex 1 or 2 material differs from vertex 0
- triangle_count_out  output  COUNT_WIDTH  number of triangles handed off (valid_out && ready_in)

Behaviour:
- One clock domain. All state is reset synchronously when rst_n_in=0 at a clk_in edge.
- Reset values: valid_out=0, mismatch_out=0, triangle_count_out=0, triangle_out=0, material_out=0, slot counter=0, state=COLLECT.
- Vertex accept = valid_in && ready_out.
- States:
  - COLLECT: slot counter 0..2.
    - Each accept writes vertex_in into triangle register slot[counter]; material_in is latched when counter=0 and compared otherwise; counter increments.
    - Mismatch accumulates as a sticky bit per triangle.
    - On the accept at counter=2: go to FULL, set valid_out=1 next cycle, reset counter to 0. Latency from third accept to valid_out is 1 cycle.
  - FULL: valid_out=1; triangle_out, material_out and mismatch_out are held stable until the handoff.
    - On ready_in=1: count increments, valid_out drops next cycle unless a new triangle completes in the same cycle.
- ready_out = (state==COLLECT) || (valid_out && ready_in).
  - A vertex accepted in the handoff cycle becomes slot 0 of the next triangle, giving zero-bubble throughput of 1 vertex/cycle.
  - The next triangle's slot 0 is held in a separate staging register so the presented triangle stays stable.
  - Equivalent implementation: a two-deep triangle buffer, provided the port timing is identical.
- ready_out is combinational from ready_in; valid_out is registered.
- Simultaneous handoff and accept: both take effect. The count increments, and the new vertex enters slot 0 of the next triangle.
- flush_in=1 (COLLECT or FULL):
  - Clears the partial counter and the mismatch accumulator for the triangle being collected.
  - A completed triangle held in FULL is not discarded.
  - A vertex presented the same cycle as flush_in is accepted as slot 0 of a fresh triangle (flush first, then accept).
  - ready_out is unaffected by flush_in.
- Triangle counter wraps from 2^COUNT_WIDTH-1 to 0 with no saturation.
- Reset asserted mid-triangle or while in FULL drops valid_out and discards all collected vertices with no partial output.
- No backpressure-free loss: a vertex is never accepted when ready_out=0, and a triangle is never overwritten before its handoff.

Test Plan:
- Reset, then 3 vertices back-to-back (x-lane values 1,2,3; material 0x005 on each) with ready_in=1 → 1 cycle after third accept, valid_out=1, triangle_out x-lanes [0]=1,[1]=2,[2]=3, material_out=0x005, mismatch_out=0; count 0→1 on handoff.
- 9 vertices streamed every cycle with ready_in=1 → 3 triangles, ready_out never drops, triangle_count_out=3.
- ready_in held 0 after the first triangle completes → ready_out=0 and triangle_out stable for 10 cycles; raise ready_in → handoff, and a vertex presented that cycle is accepted as slot 0.
- Materials 0x001,0x001,0x002 → mismatch_out=1, material_out=0x001; the following triangle with uniform materials shows mismatch_out=0.
- Accept 2 vertices, pulse flush_in, then send 3 vertices (A,B,C) → emitted triangle is exactly A,B,C.
- With COUNT_WIDTH=2, emit 5 triangles → triangle_count_out sequence 1,2,3,0,1; assert rst_n_in=0 after 1 vertex of the next triangle → valid_out=0, count=0, and the next 3 vertices form a clean triangle.
